// File: rtl/dbg_uart_tx_if.sv
// Byte-stream handshake into the debug UART transmitter.
interface dbg_uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/dbg_uart_tx.sv
// Debug UART transmitter: small byte FIFO feeding an 8N1 serialiser.
// Frames follow one another with no idle gap while the FIFO holds data.
module dbg_uart_tx #(
  parameter int CLKS_PER_BIT = 278,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  dbg_uart_tx_if.slave                  bus,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, baud_end;

  assign full        = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty       = (level_q == '0);
  assign bus.ready_o = !full && !rst_i;
  assign push        = bus.valid_i && bus.ready_o;
  assign baud_end    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  assign tx_o    = tx_q;
  assign busy_o  = (state_q != IDLE) || !empty;
  assign level_o = level_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Drive the next bit straight from the shifter so tx stays registered.
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        tx_d   = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the control flops.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_ptr_q] <= bus.data_i;
  end
endmodule

// File: tb/tb_dbg_uart_tx.sv
// Bench for dbg_uart_tx: directed pushes, UART-decoding monitor against a
// scoreboard of expected bytes, plus level/busy/tx spot checks.
module tb_dbg_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic       busy;
  logic [2:0] level;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         stall_cnt = 0;
  int         stall_bad = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  dbg_uart_tx_if bus ();

  dbg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .tx_o   (tx),
    .busy_o (busy),
    .level_o(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic adv(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Monitor: decode each frame on tx and compare to the scoreboard head.
  initial begin : monitor
    bit         ab;
    logic [7:0] rx;
    logic       s_bit;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_q.push_back(cyc);
        ab = 1'b0;
        rx = '0;
        adv(1, ab);
        s_bit = tx;
        for (int i = 0; i < 8; i++) begin
          adv(CPB, ab);
          rx[i] = tx;
        end
        adv(CPB, ab);
        if (!ab) begin
          check("mon_start_bit", 32'(s_bit), 32'd0);
          check("mon_stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mon_unexpected_frame: got %0h expected none", rx);
          end else begin
            check("mon_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    bus.data_i  = b;
    bus.valid_i = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = bus.ready_o;
      if (!acc) begin
        stall_cnt++;
        if (level != 3'd4) stall_bad++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    bus.valid_i = 1'b0;
    if (acc) exp_q.push_back(b);
    else check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy !== 1'b0 && guard < 2000);
    check({name, "_idle_timeout"}, 32'(guard >= 2000), 32'd0);
    repeat (4) @(negedge clk);
    check({name, "_all_received"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic quiet_line(input string name, input int n);
    bit low_seen;
    low_seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check(name, 32'(low_seen), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.ready_o), 32'd1);

    // Single byte 0xA5 from idle.
    @(posedge clk);
    #1;
    push_byte(8'hA5);
    @(negedge clk);
    check("t1_level_after_push", 32'(level), 32'd1);
    check("t1_tx_still_idle", 32'(tx), 32'd1);
    @(negedge clk);
    check("t1_tx_start", 32'(tx), 32'd0);
    check("t1_level_after_pop", 32'(level), 32'd0);
    check("t1_busy_frame", 32'(busy), 32'd1);
    repeat (39) @(negedge clk);
    check("t1_busy_last_stop", 32'(busy), 32'd1);
    check("t1_tx_last_stop", 32'(tx), 32'd1);
    @(negedge clk);
    check("t1_busy_drop", 32'(busy), 32'd0);
    wait_idle("t1");

    // Three consecutive bytes, back-to-back frames.
    start_q.delete();
    @(posedge clk);
    #1;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h00;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h00);
    bus.data_i = 8'hFF;
    @(negedge clk);
    check("t2_level_n0", 32'(level), 32'd1);
    @(posedge clk);
    #1;
    exp_q.push_back(8'hFF);
    bus.data_i = 8'h55;
    @(negedge clk);
    check("t2_level_n1", 32'(level), 32'd1);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h55);
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("t2_level_n2", 32'(level), 32'd2);
    repeat (39) @(negedge clk);
    check("t2_level_after_pop2", 32'(level), 32'd1);
    repeat (40) @(negedge clk);
    check("t2_level_after_pop3", 32'(level), 32'd0);
    wait_idle("t2");
    check("t2_frame_count", 32'(start_q.size()), 32'd3);
    if (start_q.size() >= 3) begin
      check("t2_spacing_1", 32'(start_q[1] - start_q[0]), 32'd40);
      check("t2_spacing_2", 32'(start_q[2] - start_q[1]), 32'd40);
    end

    // Six bytes with valid held; FIFO fills and back-pressures.
    stall_cnt = 0;
    stall_bad = 0;
    @(posedge clk);
    #1;
    push_byte(8'h01);
    push_byte(8'h82);
    push_byte(8'hC3);
    push_byte(8'h7E);
    push_byte(8'h18);
    push_byte(8'hE7);
    check("t3_backpressure_seen", 32'(stall_cnt > 0), 32'd1);
    check("t3_stall_only_when_full", 32'(stall_bad), 32'd0);
    wait_idle("t3");

    // Valid pulsed during reset is ignored.
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h99;
    @(negedge clk);
    check("t4_ready_in_reset", 32'(bus.ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("t4_level_no_capture", 32'(level), 32'd0);
    check("t4_busy_no_capture", 32'(busy), 32'd0);
    quiet_line("t4_no_frame", 60);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    @(posedge clk);
    #1;
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    @(negedge clk);
    check("t5_level_queued", 32'(level), 32'd2);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_tx_after_abort", 32'(tx), 32'd1);
    check("t5_level_after_abort", 32'(level), 32'd0);
    check("t5_busy_after_abort", 32'(busy), 32'd0);
    quiet_line("t5_no_further_frames", 100);

    // Push landing on the last stop cycle with the FIFO empty.
    start_q.delete();
    @(posedge clk);
    #1;
    push_byte(8'h5A);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b1;
    bus.data_i  = 8'hC3;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    exp_q.push_back(8'hC3);
    @(negedge clk);
    check("t6_tx_gap", 32'(tx), 32'd1);
    check("t6_busy_gap", 32'(busy), 32'd1);
    check("t6_level_gap", 32'(level), 32'd1);
    @(negedge clk);
    check("t6_tx_start", 32'(tx), 32'd0);
    wait_idle("t6");
    check("t6_frame_count", 32'(start_q.size()), 32'd2);
    if (start_q.size() >= 2)
      check("t6_spacing", 32'(start_q[1] - start_q[0]), 32'd41);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
